// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector.
// Bits arrive on I qualified by in_valid and are shifted into a history
// register.  F pulses for one cycle on the edge that accepts the last bit
// of a match.  Overlapping or non-overlapping detection is selectable per
// accepted bit, and a saturating counter tallies matches.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b0000_1001),
    parameter int DEFAULT_LEN = 4,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               I,
    input  logic               in_valid,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               overlap,
    input  logic               clr_cnt,
    output logic               F,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] pat_reg;
    logic [MAX_LEN-1:0] pat_next;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   len_next;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic               f_next;
    logic [CNT_W-1:0]   cnt_next;

    logic [MAX_LEN-1:0] shifted;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   len_clamped;
    logic               match;

    // Mask selecting only the low len_reg bits, so pattern bits above the active length are ignored.
    always_comb begin
        len_mask = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            len_mask[k] = (k < int'(len_reg));
        end
    end

    // A loaded length of 0 becomes 1 and anything beyond MAX_LEN is capped.
    always_comb begin
        len_clamped = len_in;
        if (len_in == '0) begin
            len_clamped = LEN_W'(1);
        end else if (int'(len_in) > MAX_LEN) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // Next-state logic: load has priority, then an accepted bit, otherwise hold with F low.
    always_comb begin
        pat_next  = pat_reg;
        len_next  = len_reg;
        hist_next = hist;
        fill_next = fill;
        f_next    = 1'b0;
        match     = 1'b0;
        shifted   = {hist[MAX_LEN-2:0], I};
        fill_inc  = (fill < len_reg) ? (fill + LEN_W'(1)) : len_reg;

        if (pat_load) begin
            pat_next  = pat_in;
            len_next  = len_clamped;
            hist_next = '0;
            fill_next = '0;
        end else if (in_valid) begin
            hist_next = shifted;
            fill_next = fill_inc;
            match = (fill_inc == len_reg) &&
                    (((shifted ^ pat_reg) & len_mask) == '0);
            f_next = match;
            if (match && !overlap) begin
                fill_next = '0;
            end
        end
    end

    // Counter clears synchronously on clr_cnt, otherwise counts matches and sticks at all-ones.
    always_comb begin
        cnt_next = match_cnt;
        if (clr_cnt) begin
            cnt_next = '0;
        end else if (match && (match_cnt != '1)) begin
            cnt_next = match_cnt + CNT_W'(1);
        end
    end

    // State register; reset restores the default pattern and empties the history immediately.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            pat_reg   <= DEFAULT_PAT;
            len_reg   <= LEN_W'(DEFAULT_LEN);
            hist      <= '0;
            fill      <= '0;
            F         <= 1'b0;
            match_cnt <= '0;
        end else begin
            pat_reg   <= pat_next;
            len_reg   <= len_next;
            hist      <= hist_next;
            fill      <= fill_next;
            F         <= f_next;
            match_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param.
// A driver applies one cycle of stimulus at a time and pushes the reference
// model's expected F/match_cnt into a queue; a monitor pops and compares
// just after every rising edge.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               i_bit;
    logic               in_valid;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   len_in;
    logic               overlap;
    logic               clr_cnt;
    logic               f;
    logic [CNT_W-1:0]   match_cnt;

    typedef struct {
        bit f;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the accepted bits since the last restart, newest last.
    bit [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_bits[$];
    int               m_cnt;

    int checks = 0;
    int passes = 0;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .CNT_W(CNT_W)
    ) dut (
        .Clk(clk),
        .reset(reset),
        .I(i_bit),
        .in_valid(in_valid),
        .pat_load(pat_load),
        .pat_in(pat_in),
        .len_in(len_in),
        .overlap(overlap),
        .clr_cnt(clr_cnt),
        .F(f),
        .match_cnt(match_cnt)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_pat = MAX_LEN'(8'b0000_1001);
        m_len = 4;
        m_bits.delete();
        m_cnt = 0;
    endtask

    // Drive one cycle of inputs at the falling edge and record what the model expects after the next rising edge.
    task automatic apply_stimulus(input bit b, input bit v, input bit ld,
                                  input logic [MAX_LEN-1:0] pin, input int lin,
                                  input bit ov, input bit clr);
        bit   match;
        exp_t e;
        @(negedge clk);
        i_bit    = b;
        in_valid = v;
        pat_load = ld;
        pat_in   = pin;
        len_in   = LEN_W'(lin);
        overlap  = ov;
        clr_cnt  = clr;

        match = 1'b0;
        if (ld) begin
            m_pat = pin;
            m_len = (lin < 1) ? 1 : ((lin > MAX_LEN) ? MAX_LEN : lin);
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() > m_len) void'(m_bits.pop_front());
            if (m_bits.size() == m_len) begin
                match = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (m_bits[k] != m_pat[m_len-1-k]) match = 1'b0;
                end
            end
            if (match && !ov) m_bits.delete();
        end
        if (clr) m_cnt = 0;
        else if (match && m_cnt < CNT_MAX) m_cnt++;

        e.f   = match;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // Send n bits MSB first with in_valid high and the given overlap mode.
    task automatic send_bits(input logic [31:0] bits, input int n, input bit ov);
        logic [31:0] v;
        v = bits;
        for (int k = n - 1; k >= 0; k--) begin
            apply_stimulus(v[k], 1'b1, 1'b0, '0, 0, ov, 1'b0);
        end
    endtask

    task automatic load_pattern(input logic [MAX_LEN-1:0] pin, input int lin, input bit b);
        apply_stimulus(b, 1'b1, 1'b1, pin, lin, 1'b1, 1'b0);
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 0, 1'b1, 1'b0);
    endtask

    task automatic clear_count();
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, 0, 1'b1, 1'b1);
    endtask

    // Assert reset part-way through a cycle, check outputs drop at once, hold it across an edge, then release.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_output({tag, "_F_async"}, int'(f), 0);
        check_output({tag, "_cnt_async"}, int'(match_cnt), 0);
        @(posedge clk);
        #1;
        check_output({tag, "_F_hold"}, int'(f), 0);
        check_output({tag, "_cnt_hold"}, int'(match_cnt), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare every pending expectation just after the rising edge it belongs to.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("F", int'(f), int'(e.f));
            check_output("match_cnt", int'(match_cnt), e.cnt);
        end
    end

    initial begin
        int wait_cycles;
        reset    = 1'b1;
        i_bit    = 1'b0;
        in_valid = 1'b0;
        pat_load = 1'b0;
        pat_in   = '0;
        len_in   = '0;
        overlap  = 1'b1;
        clr_cnt  = 1'b0;
        model_reset();

        @(posedge clk);
        #1;
        check_output("reset_F", int'(f), 0);
        check_output("reset_cnt", int'(match_cnt), 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] overlapping 1001001");
        send_bits(32'b1001001, 7, 1'b1);
        clear_count();

        $display("[TB] non-overlapping 1001001");
        send_bits(32'b1001001, 7, 1'b0);
        clear_count();

        $display("[TB] valid gaps");
        apply_stimulus(1'b1, 1'b1, 1'b0, '0, 0, 1'b1, 1'b0);
        idle_cycle();
        idle_cycle();
        apply_stimulus(1'b0, 1'b1, 1'b0, '0, 0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, '0, 0, 1'b1, 1'b0);
        idle_cycle();
        apply_stimulus(1'b1, 1'b1, 1'b0, '0, 0, 1'b1, 1'b0);
        idle_cycle();

        $display("[TB] runtime load");
        send_bits(32'b11, 2, 1'b1);
        load_pattern(MAX_LEN'(3'b110), 3, 1'b0);
        send_bits(32'b110, 3, 1'b1);
        load_pattern(MAX_LEN'(8'b1), 0, 1'b1);
        send_bits(32'b1011001, 7, 1'b1);
        load_pattern(MAX_LEN'(8'b1), 0, 1'b1);
        send_bits(32'b1011001, 7, 1'b0);

        $display("[TB] saturation and clear");
        clear_count();
        send_bits(32'b11111, 5, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0, '0, 0, 1'b1, 1'b1);

        $display("[TB] async reset mid-pattern");
        send_bits(32'b11, 2, 1'b1);
        load_pattern(MAX_LEN'(8'b1001), 4, 1'b0);
        send_bits(32'b100, 3, 1'b1);
        pulse_reset("midreset");
        send_bits(32'b1, 1, 1'b1);
        pulse_reset("midreset2");
        send_bits(32'b1001, 4, 1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            bit ld;
            bit clr;
            ld  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 29) == 0);
            apply_stimulus(1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) != 0),
                           ld,
                           MAX_LEN'($urandom),
                           $urandom_range(0, 4),
                           1'($urandom_range(0, 1)),
                           clr);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised, runtime-programmable serial bit-pattern detector. It is the successor to the fixed "1001" Moore detector and sits on the same serial input path. Pattern and length are loadable at run time, and input bits are qualified by a valid strobe. Overlapping or non-overlapping detection is selectable, and a saturating match counter is provided. Output F stays a registered Moore-style one-cycle pulse.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
CNT_W, 8, width of match counter
DEFAULT_PAT, 8'b0000_1001, pattern after reset (low MAX_LEN bits used)
DEFAULT_LEN, 4, pattern length after reset (1..MAX_LEN)

Ports:
Clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
I  input  1  serial data bit
in_valid  input  1  I is accepted on a rising edge only when in_valid=1
pat_load  input  1  load pat_in/len_in this edge
pat_in  input  MAX_LEN  new pattern; bit[len-1] = first bit of sequence, bit[0] = last
len_in  input  $clog2(MAX_LEN+1)  new pattern length
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
clr_cnt  input  1  synchronous clear of match_cnt
F  output  1  registered match pulse
match_cnt  output  CNT_W  saturating count of matches

Behaviour:
- Reset (async, immediate): pat_reg=DEFAULT_PAT, len_reg=DEFAULT_LEN, hist=0, fill=0, F=0, match_cnt=0.
- State: hist (MAX_LEN shift register, newest bit in [0]); fill (0..len_reg) counts valid history bits.
- Accepted bit (in_valid=1, pat_load=0):
  - hist_n = {hist[MAX_LEN-2:0], I}; fill_n = min(fill+1, len_reg).
  - match = (fill_n == len_reg) and (hist_n[len_reg-1:0] == pat_reg[len_reg-1:0]); bits above len_reg are ignored.
  - F <= match.
  - On match with overlap=1: fill unchanged. With overlap=0: fill <= 0, so the next match needs len_reg fresh bits.
- Latency: F is high for exactly one cycle, starting at the edge that accepts the final pattern bit.
- No accepted bit (in_valid=0): hist and fill hold; F <= 0.
- pat_load=1:
  - pat_reg <= pat_in; len_reg <= clamp(len_in): 0 loads 1, values > MAX_LEN load MAX_LEN.
  - hist <= 0, fill <= 0, F <= 0.
  - The same-cycle I is discarded; load has priority over in_valid.
  - match_cnt is unaffected.
- match_cnt:
  - Increments on each match and saturates at all-ones (no wrap).
  - clr_cnt=1 sets it to 0 and wins over a simultaneous match; F still pulses for that match.
- overlap is sampled per accepted bit; a change applies from the next accepted bit.
- Reset asserted mid-pattern discards all partial history; matching restarts from empty.
- Next-state logic is fully combinational with defaults; no latches.

Test Plan:
1. Reset defaults, overlap=1, stream 1,0,0,1,0,0,1 with in_valid=1 -> F high after bits 4 and 7 only; match_cnt=2.
2. Same stream, overlap=0 -> F high after bit 4 only; bit 7 gives no match because fill=3; match_cnt=1.
3. Default pattern, stream 1,(in_valid=0 x2),0,0,(gap),1 -> exactly one F pulse, at the edge accepting the final 1; F=0 on all gap cycles.
4. After accepting 1,1, pulse pat_load with pat_in=3'b110, len_in=3, I=0 -> no match; then 1,1,0 -> F pulse. Then load len_in=0 with pat_in[0]=1 -> len_reg=1; every accepted 1 pulses F, every 0 does not.
5. CNT_W=2, drive 5 matches -> match_cnt stops at 3. Then assert clr_cnt on the same edge as a match -> match_cnt=0 and F=1.
6. Default pattern, stream 1,0,0, assert reset asynchronously mid-cycle -> F and match_cnt go to 0 immediately. After release, a single 1 gives no F; a full 1,0,0,1 gives F.
